// File: rtl/xvc_pkg.sv
// Shared constants and types for the XVC JTAG shift engine.
// Optional build macro XVC_TDO_SYNC_EN is consumed by xvc_shift_engine.
package xvc_pkg;

    localparam logic [1:0] OP_WAIT  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    localparam logic [4:0] OFS_LENGTH  = 5'h00;
    localparam logic [4:0] OFS_TMS     = 5'h04;
    localparam logic [4:0] OFS_TDI     = 5'h08;
    localparam logic [4:0] OFS_TDO     = 5'h0C;
    localparam logic [4:0] OFS_CONTROL = 5'h10;

    localparam int unsigned MAX_LEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } eng_state_e;

    function automatic logic [5:0] clamp_len(input logic [31:0] v);
        return (v > 32'(MAX_LEN)) ? 6'(MAX_LEN) : v[5:0];
    endfunction

endpackage

// File: rtl/xvc_shift_engine.sv
// TCK generator and bit shifter: drives TMS/TDI LSB first and captures TDO.
// XVC_TDO_SYNC_EN adds a two-flop TDO synchronizer and delays the sample by 2 clk.
module xvc_shift_engine
    import xvc_pkg::*;
#(
    parameter int unsigned TCK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [5:0]  length_i,
    input  logic [31:0] tms_i,
    input  logic [31:0] tdi_i,
    input  logic        tdo_i,
    output logic [31:0] tdo_word_o,
    output logic        running_o,
    output eng_state_e  state_o,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o
);

    localparam int CW = $clog2(TCK_DIV + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TCK_DIV - 1);

    logic tdo_s;

`ifdef XVC_TDO_SYNC_EN
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(2);
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], tdo_i};
    end
    assign tdo_s = sync_q[1];
`else
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(0);
    assign tdo_s = tdo_i;
`endif

    eng_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    idx_q;
    logic          tck_q;
    logic          tms_q;
    logic          tdi_q;
    logic [31:0]   tdo_q;

    logic [4:0] idx_nx;
    logic       last_bit;

    assign idx_nx   = idx_q + 5'd1;
    assign last_bit = ({1'b0, idx_q} == (length_i - 6'd1));

    // tms_i/tdi_i/length_i are read live: the register file refuses writes while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            tdo_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        tdo_q <= '0;
                        idx_q <= '0;
                        cnt_q <= '0;
                        if (length_i != 6'd0) begin
                            state_q <= ST_LOW;
                            tms_q   <= tms_i[0];
                            tdi_q   <= tdi_i[0];
                        end
                    end
                end
                ST_LOW: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= '0;
                        tck_q   <= 1'b1;
                        state_q <= ST_HIGH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == SAMPLE_CNT) tdo_q[idx_q] <= tdo_s;
                    if (cnt_q == LAST_CNT) begin
                        cnt_q <= '0;
                        tck_q <= 1'b0;
                        if (last_bit) begin
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_nx;
                            tms_q   <= tms_i[idx_nx];
                            tdi_q   <= tdi_i[idx_nx];
                            state_q <= ST_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tdo_word_o = tdo_q;
    assign running_o  = (state_q != ST_IDLE);
    assign state_o    = state_q;
    assign tck_o      = tck_q;
    assign tms_o      = tms_q;
    assign tdi_o      = tdi_q;

endmodule

// File: rtl/xvc_jtag_shifter.sv
// Register-access front end for the XVC JTAG shifter: decode, handshake and register file.
// Build macro XVC_TDO_SYNC_EN (synchronized TDO, needs TCK_DIV >= 3) is passed to the engine.
module xvc_jtag_shifter
    import xvc_pkg::*;
#(
    parameter int unsigned TCK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  opcode,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        wdone,
    output logic        busy,
    output logic        jtag_tck,
    output logic        jtag_tms,
    output logic        jtag_tdi,
    input  logic        jtag_tdo
);

    // Handshake: a WRITE/READ opcode with busy=0 is taken at cycle T; wdone or rvalid
    // pulses at T+1 with rdata, busy covers T+1..T+2 so a request still held is not re-taken.
    logic        busy1_q, busy2_q;
    logic        wdone_q, rvalid_q;
    logic [31:0] rdata_q;
    logic [5:0]  len_q;
    logic [31:0] tms_q, tdi_q;

    logic        accept, is_wr, is_rd;
    logic        addr_ok, sel_len, sel_tms, sel_tdi, sel_tdo, sel_ctrl;
    logic        start;
    logic [31:0] rd_word;
    logic [31:0] eng_tdo_word;
    logic        eng_running;
    eng_state_e  eng_state;

    assign busy   = busy1_q | busy2_q;
    assign accept = !busy && ((opcode == OP_WRITE) || (opcode == OP_READ));
    assign is_wr  = accept && (opcode == OP_WRITE);
    assign is_rd  = accept && (opcode == OP_READ);

    assign addr_ok  = (addr[15:5] == 11'd0);
    assign sel_len  = addr_ok && (addr[4:0] == OFS_LENGTH);
    assign sel_tms  = addr_ok && (addr[4:0] == OFS_TMS);
    assign sel_tdi  = addr_ok && (addr[4:0] == OFS_TDI);
    assign sel_tdo  = addr_ok && (addr[4:0] == OFS_TDO);
    assign sel_ctrl = addr_ok && (addr[4:0] == OFS_CONTROL);

    assign start = is_wr && sel_ctrl && wdata[0] && (eng_state == ST_IDLE);

    always_comb begin
        rd_word = '0;
        if (sel_len)  rd_word = {26'd0, len_q};
        if (sel_tms)  rd_word = tms_q;
        if (sel_tdi)  rd_word = tdi_q;
        if (sel_tdo)  rd_word = eng_tdo_word;
        if (sel_ctrl) rd_word = {31'd0, eng_running};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy1_q  <= 1'b0;
            busy2_q  <= 1'b0;
            wdone_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            len_q    <= '0;
            tms_q    <= '0;
            tdi_q    <= '0;
        end else begin
            busy1_q  <= accept;
            busy2_q  <= busy1_q;
            wdone_q  <= is_wr;
            rvalid_q <= is_rd;
            if (is_rd) rdata_q <= rd_word;
            if (is_wr && !eng_running) begin
                if (sel_len) len_q <= clamp_len(wdata);
                if (sel_tms) tms_q <= wdata;
                if (sel_tdi) tdi_q <= wdata;
            end
        end
    end

    xvc_shift_engine #(
        .TCK_DIV (TCK_DIV)
    ) u_engine (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .length_i   (len_q),
        .tms_i      (tms_q),
        .tdi_i      (tdi_q),
        .tdo_i      (jtag_tdo),
        .tdo_word_o (eng_tdo_word),
        .running_o  (eng_running),
        .state_o    (eng_state),
        .tck_o      (jtag_tck),
        .tms_o      (jtag_tms),
        .tdi_o      (jtag_tdi)
    );

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign wdone  = wdone_q;

endmodule

// File: tb/tb_xvc_jtag_shifter.sv
// Directed bench for xvc_jtag_shifter: bus handshake, register file, loopback shifts, reset abort.
module tb_xvc_jtag_shifter;

`ifdef XVC_TDO_SYNC_EN
    localparam int DIV = 3;
`else
    localparam int DIV = 2;
`endif

    localparam logic [15:0] A_LEN  = 16'h0000;
    localparam logic [15:0] A_TMS  = 16'h0004;
    localparam logic [15:0] A_TDI  = 16'h0008;
    localparam logic [15:0] A_TDO  = 16'h000C;
    localparam logic [15:0] A_CTRL = 16'h0010;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [1:0]  opcode;
    logic [31:0] rdata;
    logic        rvalid, wdone, busy;
    logic        jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
    logic        tdo_inv;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;
    int tck_edges = 0;
    logic tck_prev = 1'b0;
    logic [0:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign jtag_tdo = tdo_inv ? ~jtag_tdi : jtag_tdi;

    xvc_jtag_shifter #(.TCK_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .opcode   (opcode),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .wdone    (wdone),
        .busy     (busy),
        .jtag_tck (jtag_tck),
        .jtag_tms (jtag_tms),
        .jtag_tdi (jtag_tdi),
        .jtag_tdo (jtag_tdo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // scoreboard: every TCK rising edge must carry the next expected TMS bit
    always @(posedge clk) begin
        #1;
        if (jtag_tck && !tck_prev) begin
            tck_edges++;
            if (exp_q.size() > 0) check("tms_bit", 32'(jtag_tms), 32'(exp_q.pop_front()));
        end
        tck_prev = jtag_tck;
    end

    // driver tasks; 'at' >= 0 places the accept at that exact cycle
    task automatic wait_cycle(input int at);
        int guard = 0;
        if (at >= 0)
            while (cyc < at && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input string tag);
        @(negedge clk);
        wait_cycle(-1);
        addr = a; wdata = d; opcode = 2'd1; last_acc = cyc;
        @(negedge clk);
        check({tag, "_wdone"}, 32'(wdone), 32'd1);
        opcode = 2'd0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [15:0] a, input int at, output logic [31:0] d);
        @(negedge clk);
        wait_cycle(at);
        addr = a; opcode = 2'd2; last_acc = cyc;
        @(negedge clk);
        check("rvalid", 32'(rvalid), 32'd1);
        d = rdata;
        opcode = 2'd0;
        @(negedge clk);
    endtask

    task automatic read_check(input logic [15:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        bus_read(a, -1, d);
        check(tag, d, exp);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] d;
        int polls = 0;
        d = 32'd1;
        while (d != 32'd0 && polls < 100) begin
            bus_read(A_CTRL, -1, d);
            polls++;
        end
        check({tag, "_idle"}, d, 32'd0);
    endtask

    task automatic push_tms(input logic [31:0] tms, input int n);
        logic [0:0] b;
        for (int i = 0; i < n; i++) begin
            b = tms[i];
            exp_q.push_back(b);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int t0, e0, bnd, polls;

        rst = 1'b1; opcode = 2'd0; addr = '0; wdata = '0; tdo_inv = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdata",  rdata,            32'd0);
        check("rst_rvalid", 32'(rvalid),      32'd0);
        check("rst_wdone",  32'(wdone),       32'd0);
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_tck",    32'(jtag_tck),    32'd0);
        check("rst_tms",    32'(jtag_tms),    32'd1);
        check("rst_tdi",    32'(jtag_tdi),    32'd0);
        rst = 1'b0;
        read_check(A_LEN,  32'd0, "def_len");
        read_check(A_TMS,  32'd0, "def_tms");
        read_check(A_TDO,  32'd0, "def_tdo");
        read_check(A_CTRL, 32'd0, "def_ctrl");

        // handshake: write held T..T+2, new read at T+3
        @(negedge clk);
        addr = A_TMS; wdata = 32'h0000_0012; opcode = 2'd1;
        @(negedge clk);
        check("hs_wdone_t1", 32'(wdone), 32'd1);
        check("hs_busy_t1",  32'(busy),  32'd1);
        @(negedge clk);
        check("hs_wdone_t2", 32'(wdone), 32'd0);
        check("hs_busy_t2",  32'(busy),  32'd1);
        @(negedge clk);
        check("hs_wdone_t3", 32'(wdone), 32'd0);
        check("hs_busy_t3",  32'(busy),  32'd0);
        addr = A_TMS; opcode = 2'd2;
        @(negedge clk);
        check("hs_rvalid_t4", 32'(rvalid), 32'd1);
        check("hs_rdata_t4",  rdata, 32'h0000_0012);
        opcode = 2'd0;
        @(negedge clk);

        // clamp and decode
        bus_write(A_LEN, 32'd40, "len40");
        read_check(A_LEN, 32'd32, "len_clamp40");
        bus_write(A_LEN, 32'd31, "len31");
        read_check(A_LEN, 32'd31, "len_keep31");
        bus_write(16'h0014, 32'hFFFF_FFFF, "bad_wr");
        read_check(16'h0014, 32'd0, "bad_rd_14");
        read_check(16'h0001, 32'd0, "bad_rd_01");
        bus_write(16'h0104, 32'h0000_DEAD, "alias_wr");
        read_check(16'h0104, 32'd0, "bad_rd_104");
        read_check(A_TMS, 32'h0000_0012, "alias_tms");
        bus_write(A_TDO, 32'hFFFF_FFFF, "tdo_wr");
        read_check(A_TDO, 32'd0, "tdo_ro");

        // loopback, 8 bits
        bus_write(A_LEN, 32'd8, "lb_len");
        bus_write(A_TMS, 32'h0000_00A5, "lb_tms");
        bus_write(A_TDI, 32'h0000_003C, "lb_tdi");
        push_tms(32'h0000_00A5, 8);
        e0 = tck_edges;
        bus_write(A_CTRL, 32'd1, "lb_start");
        wait_idle("lb");
        check("lb_edges", 32'(tck_edges - e0), 32'd8);
        check("lb_q_empty", 32'(exp_q.size()), 32'd0);
        read_check(A_TDO, 32'h0000_003C, "lb_tdo");
        check("lb_tms_hold", 32'(jtag_tms), 32'd1);
        check("lb_tdi_hold", 32'(jtag_tdi), 32'd0);

        // inverted TDO, 5 bits: bit order and zeroed upper bits
        tdo_inv = 1'b1;
        bus_write(A_LEN, 32'd5, "inv_len");
        bus_write(A_TMS, 32'h0000_000A, "inv_tms");
        bus_write(A_TDI, 32'hFFFF_FF13, "inv_tdi");
        push_tms(32'h0000_000A, 5);
        e0 = tck_edges;
        bus_write(A_CTRL, 32'd1, "inv_start");
        wait_idle("inv");
        check("inv_edges", 32'(tck_edges - e0), 32'd5);
        read_check(A_TDO, 32'h0000_000C, "inv_tdo");
        tdo_inv = 1'b0;

        // writes during a shift are acknowledged and dropped
        bus_write(A_LEN, 32'd8, "ign_len");
        bus_write(A_TMS, 32'h0000_00A5, "ign_tms");
        push_tms(32'h0000_00A5, 8);
        e0 = tck_edges;
        bus_write(A_CTRL, 32'd1, "ign_start");
        t0 = last_acc;
        bus_write(A_TMS, 32'h0000_00FF, "ign_tms_run");
        bus_write(A_LEN, 32'd3, "ign_len_run");
        bus_write(A_CTRL, 32'd0, "ign_ctrl0");
        bus_read(A_CTRL, -1, d);
        check("ign_ctrl_run", d, (last_acc < t0 + 1 + 8 * 2 * DIV) ? 32'd1 : 32'd0);
        wait_idle("ign");
        check("ign_edges", 32'(tck_edges - e0), 32'd8);
        read_check(A_TMS, 32'h0000_00A5, "ign_tms_kept");
        read_check(A_LEN, 32'd8, "ign_len_kept");

        // polling, 32 bits, boundary read one cycle before completion
        bus_write(A_LEN, 32'd32, "poll_len");
        bus_write(A_TMS, 32'hFFFF_0000, "poll_tms");
        bus_write(A_TDI, 32'h1234_5678, "poll_tdi");
        push_tms(32'hFFFF_0000, 32);
        e0 = tck_edges;
        bus_write(A_CTRL, 32'd1, "poll_start");
        t0 = last_acc;
        bnd = t0 + 1 + 32 * 2 * DIV;
        polls = 0;
        while (cyc + 4 <= bnd - 1 && polls < 100) begin
            bus_read(A_CTRL, -1, d);
            check("poll_run", d, (last_acc >= bnd) ? 32'd0 : 32'd1);
            polls++;
        end
        bus_read(A_CTRL, bnd - 1, d);
        check("poll_before_end", d, (last_acc >= bnd) ? 32'd0 : 32'd1);
        bus_read(A_CTRL, -1, d);
        check("poll_after_end", d, (last_acc >= bnd) ? 32'd0 : 32'd1);
        check("poll_edges", 32'(tck_edges - e0), 32'd32);
        read_check(A_TDO, 32'h1234_5678, "poll_tdo");

        // short shift, read exactly at the completion cycle
        bus_write(A_LEN, 32'd3, "exact_len");
        push_tms(32'hFFFF_0000, 3);
        bus_write(A_CTRL, 32'd1, "exact_start");
        t0 = last_acc;
        bus_read(A_CTRL, t0 + 1 + 3 * 2 * DIV, d);
        check("exact_end", d, (last_acc >= t0 + 1 + 3 * 2 * DIV) ? 32'd0 : 32'd1);

        // reset after the 5th edge
        bus_write(A_LEN, 32'd8, "rst_len");
        bus_write(A_TMS, 32'h0000_0000, "rst_tms_w");
        bus_write(A_TDI, 32'h0000_00FF, "rst_tdi_w");
        push_tms(32'h0000_0000, 8);
        e0 = tck_edges;
        bus_write(A_CTRL, 32'd1, "rst_start");
        polls = 0;
        while (tck_edges - e0 < 5 && polls < 200) begin
            @(negedge clk);
            polls++;
        end
        check("rst_reach5", 32'(tck_edges - e0), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tck", 32'(jtag_tck), 32'd0);
        check("abort_tms", 32'(jtag_tms), 32'd1);
        rst = 1'b0;
        exp_q.delete();
        read_check(A_CTRL, 32'd0, "abort_ctrl");
        read_check(A_TDO,  32'd0, "abort_tdo");
        repeat (40) @(negedge clk);
        check("abort_no_edges", 32'(tck_edges - e0), 32'd5);

        // zero length
        bus_write(A_LEN, 32'd0, "zero_len");
        bus_write(A_TMS, 32'h0000_0000, "zero_tms");
        e0 = tck_edges;
        bus_write(A_CTRL, 32'd1, "zero_start");
        read_check(A_CTRL, 32'd0, "zero_ctrl");
        repeat (20) @(negedge clk);
        check("zero_edges", 32'(tck_edges - e0), 32'd0);
        check("zero_tms_idle", 32'(jtag_tms), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
